oam_dma_arbiter: RTL and testbench

- Shares the single system memory bus between the CPU and an OAM DMA engine.
- In idle it passes CPU bus traffic straight through to memory.
- A CPU write to the DMA register starts the engine. The engine then owns the bus and copies TRANSFER_LENGTH bytes from page {page,8'h00} to the OAM data port.
- While the engine runs, the CPU is stalled by withholding data_valid.
- Sits between cpu and the memory map decoder; all sequencing happens on CPU bus ticks.

---
 rtl/oam_dma_arbiter_if.sv | 46 ++++
 rtl/oam_dma_arbiter.sv | 155 +++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle shared by the CPU, the OAM DMA arbiter and the memory map decoder.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_address_i;
  logic        cpu_address_valid_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_data_write_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic [15:0] mem_address_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;
  logic        mem_data_valid_i;

  modport slave (
    input  cpu_address_i,
    input  cpu_address_valid_i,
    input  cpu_data_i,
    input  cpu_data_write_i,
    input  mem_data_i,
    input  mem_data_valid_i,
    output cpu_data_o,
    output cpu_data_valid_o,
    output mem_address_o,
    output mem_read_o,
    output mem_write_o,
    output mem_data_o
  );

  modport master (
    output cpu_address_i,
    output cpu_address_valid_i,
    output cpu_data_i,
    output cpu_data_write_i,
    output mem_data_i,
    output mem_data_valid_i,
    input  cpu_data_o,
    input  cpu_data_valid_o,
    input  mem_address_o,
    input  mem_read_o,
    input  mem_write_o,
    input  mem_data_o
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Memory bus arbiter between the CPU and the OAM DMA engine: CPU passthrough when idle,
// page-to-OAM copy (one read + one write per byte) on CPU bus ticks when triggered.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR    = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR   = 16'h2004,
  parameter int unsigned TRANSFER_LENGTH = 32'd256
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   bus_tick_i,
  oam_dma_arbiter_if.slave       bus,
  output logic                   dma_active_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LENGTH - 32'd1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_index;
  logic [7:0] w_index_nxt;
  logic [7:0] r_page;
  logic [7:0] w_page_nxt;
  logic [7:0] r_latch;
  logic [7:0] w_latch_nxt;
  logic       r_tick_parity;
  logic       r_dma_active;
  logic       w_trigger;
  logic       w_last_byte;

  function automatic logic f_next_parity(input logic parity, input logic tick);
    return parity ^ tick;
  endfunction

  // Trigger detect and last-byte detect
  always_comb begin
    w_trigger   = (r_state == IDLE) & bus.cpu_address_valid_i & bus.cpu_data_write_i &
                  (bus.cpu_address_i == DMA_REG_ADDR);
    w_last_byte = (r_index == LAST_INDEX);
  end

  // Next-state logic; the index wraps inside the page and never carries into it
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_page_nxt  = r_page;
    w_latch_nxt = r_latch;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nxt = HALT;
          w_page_nxt  = bus.cpu_data_i;
          w_index_nxt = 8'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HALT: begin
        // An odd parity here means the first read would land on the wrong half-cycle
        if (r_tick_parity) begin
          w_state_nxt = ALIGN;
        end else begin
          w_state_nxt = READ;
        end
      end
      ALIGN: begin
        w_state_nxt = READ;
      end
      READ: begin
        if (bus.mem_data_valid_i) begin
          w_latch_nxt = bus.mem_data_i;
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = READ;
        end
      end
      WRITE: begin
        if (w_last_byte) begin
          w_state_nxt = IDLE;
          w_index_nxt = 8'd0;
        end else begin
          w_state_nxt = READ;
          w_index_nxt = r_index + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_index_nxt = 8'd0;
      end
    endcase
  end

  // State registers advance only on bus ticks
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= IDLE;
      r_index       <= 8'd0;
      r_page        <= 8'd0;
      r_latch       <= 8'd0;
      r_tick_parity <= 1'b0;
      r_dma_active  <= 1'b0;
    end else begin
      r_tick_parity <= f_next_parity(r_tick_parity, bus_tick_i);
      if (bus_tick_i) begin
        r_state      <= w_state_nxt;
        r_index      <= w_index_nxt;
        r_page       <= w_page_nxt;
        r_latch      <= w_latch_nxt;
        r_dma_active <= (w_state_nxt != IDLE);
      end
    end
  end

  assign dma_active_o = r_dma_active;

  // Bus output mux: passthrough in IDLE, engine-driven otherwise with the CPU stalled
  always_comb begin
    bus.cpu_data_o       = bus.mem_data_i;
    bus.cpu_data_valid_o = 1'b0;
    bus.mem_address_o    = {r_page, r_index};
    bus.mem_read_o       = 1'b0;
    bus.mem_write_o      = 1'b0;
    bus.mem_data_o       = r_latch;
    case (r_state)
      IDLE: begin
        bus.mem_address_o    = bus.cpu_address_i;
        bus.mem_read_o       = bus.cpu_address_valid_i & ~bus.cpu_data_write_i;
        bus.mem_write_o      = bus.cpu_data_write_i & bus.cpu_address_valid_i;
        bus.mem_data_o       = bus.cpu_data_i;
        bus.cpu_data_valid_o = bus.mem_data_valid_i;
      end
      HALT, ALIGN: begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
      end
      READ: begin
        bus.mem_read_o = 1'b1;
      end
      WRITE: begin
        bus.mem_address_o = OAM_DATA_ADDR;
        bus.mem_write_o   = 1'b1;
      end
      default: begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized self-checking bench for oam_dma_arbiter against a transfer-level model
// (bytes copied, idle lead-in ticks, latched byte) plus hand-computed latency and data literals.
module tb_oam_dma_arbiter;
  logic clock_i = 1'b0;
  logic reset_i;
  logic bus_tick_i;
  logic dma_active_o;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .bus_tick_i   (bus_tick_i),
    .bus          (bus),
    .dma_active_o (dma_active_o)
  );

  always #5 clock_i = ~clock_i;

  // Memory: either the (addr&FF)^5A pattern or a fixed byte
  logic       mem_model_en;
  logic [7:0] tb_mem_data;
  assign bus.mem_data_i = mem_model_en ? (bus.mem_address_o[7:0] ^ 8'h5A) : tb_mem_data;

  int n_total = 0;
  int n_pass  = 0;

  // Transfer-level model
  bit         m_busy;
  int         m_pre;
  int         m_done;
  bit         m_have;
  logic [7:0] m_latch;
  logic [7:0] m_page;
  int         m_ticks;

  logic [7:0] oam_log[$];
  int         act_ticks;
  int         withheld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_cycle();
    logic [15:0] e_addr;
    logic        e_rd, e_wr, e_cv, chk_addr, chk_wd;
    logic [7:0]  e_wd;
    if (!reset_i) begin
      m_busy = 0; m_pre = 0; m_done = 0; m_have = 0; m_latch = 8'h00; m_page = 8'h00; m_ticks = 0;
    end
    e_addr = 16'h0000; e_rd = 1'b0; e_wr = 1'b0; e_cv = 1'b0; e_wd = 8'h00;
    chk_addr = 1'b1; chk_wd = 1'b0;
    if (!m_busy) begin
      e_addr = bus.cpu_address_i;
      e_rd   = bus.cpu_address_valid_i & ~bus.cpu_data_write_i;
      e_wr   = bus.cpu_address_valid_i & bus.cpu_data_write_i;
      e_wd   = bus.cpu_data_i;
      e_cv   = bus.mem_data_valid_i;
      chk_wd = 1'b1;
    end else if (m_pre > 0) begin
      chk_addr = 1'b0;
    end else if (!m_have) begin
      e_addr = {m_page, 8'(m_done)};
      e_rd   = 1'b1;
    end else begin
      e_addr = 16'h2004;
      e_wr   = 1'b1;
      e_wd   = m_latch;
      chk_wd = 1'b1;
    end
    check("dma_active", 32'(dma_active_o), 32'(m_busy));
    check("mem_read", 32'(bus.mem_read_o), 32'(e_rd));
    check("mem_write", 32'(bus.mem_write_o), 32'(e_wr));
    check("cpu_valid", 32'(bus.cpu_data_valid_o), 32'(e_cv));
    check("cpu_data", 32'(bus.cpu_data_o), 32'(bus.mem_data_i));
    if (chk_addr) check("mem_addr", 32'(bus.mem_address_o), 32'(e_addr));
    if (chk_wd) check("mem_wdata", 32'(bus.mem_data_o), 32'(e_wd));

    if (reset_i && bus_tick_i) begin
      if (dma_active_o) act_ticks++;
      if (dma_active_o && bus.mem_write_o && bus.mem_address_o == 16'h2004)
        oam_log.push_back(bus.mem_data_o);
      if (!m_busy) begin
        if (bus.cpu_address_valid_i && bus.cpu_data_write_i && bus.cpu_address_i == 16'h4014) begin
          m_busy = 1; m_page = bus.cpu_data_i; m_done = 0; m_have = 0;
          m_pre  = (m_ticks % 2 == 1) ? 1 : 2;
        end
      end else if (m_pre > 0) begin
        m_pre--;
      end else if (!m_have) begin
        if (bus.mem_data_valid_i) begin
          m_latch = bus.mem_data_i; m_have = 1;
        end
      end else begin
        m_have = 0; m_done++;
        if (m_done == 256) m_busy = 0;
      end
      m_ticks++;
    end
  endtask

  task automatic step();
    @(negedge clock_i);
    cmp_cycle();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_traffic(input bit quiet);
    bus.cpu_address_valid_i = quiet ? 1'b0 : 1'($urandom_range(0, 1));
    bus.cpu_data_write_i    = quiet ? 1'b0 : 1'($urandom_range(0, 1));
    bus.cpu_address_i       = 16'($urandom);
    if (bus.cpu_address_i == 16'h4014) bus.cpu_address_i = 16'h4015;
    bus.cpu_data_i          = 8'($urandom);
  endtask

  task automatic do_trigger(input bit want_odd, input logic [7:0] page);
    for (int k = 0; k < 4 && (m_ticks % 2) != int'(want_odd); k++) begin
      bus_tick_i = 1'b1;
      idle_traffic(1'b1);
      step();
    end
    bus_tick_i = 1'b1;
    bus.cpu_address_valid_i = 1'b1;
    bus.cpu_data_write_i    = 1'b1;
    bus.cpu_address_i       = 16'h4014;
    bus.cpu_data_i          = page;
    act_ticks = 0;
    oam_log.delete();
    step();
    idle_traffic(1'b1);
  endtask

  // noise: CPU hammers 8000/4014 during DMA; vmode: 0 zero-wait, 1 stall byte 10 x3, 2 random
  task automatic run_dma(input bit noise, input int vmode, input int abort_at, output bit aborted);
    bit done = 0;
    aborted = 0;
    withheld = 0;
    for (int c = 0; c < 20000; c++) begin
      bus_tick_i = ($urandom_range(0, 3) != 0);
      if (noise) begin
        bus.cpu_address_valid_i = 1'($urandom_range(0, 1));
        bus.cpu_data_write_i    = 1'($urandom_range(0, 1));
        bus.cpu_address_i       = bus.cpu_data_write_i ? 16'h4014 : 16'h8000;
        bus.cpu_data_i          = 8'h07;
      end else begin
        idle_traffic(1'b1);
      end
      bus.mem_data_valid_i = 1'b1;
      if (vmode == 1 && m_busy && m_pre == 0 && !m_have && m_done == 10 && withheld < 3) begin
        bus.mem_data_valid_i = 1'b0;
        if (bus_tick_i) withheld++;
      end else if (vmode == 2) begin
        bus.mem_data_valid_i = ($urandom_range(0, 2) != 0);
      end
      step();
      if (abort_at > 0 && oam_log.size() == abort_at) begin
        aborted = 1; done = 1; break;
      end
      if (!dma_active_o) begin
        done = 1; break;
      end
    end
    idle_traffic(1'b1);
    bus.mem_data_valid_i = 1'b1;
    check("dma_done_in_budget", 32'(done), 32'd1);
  endtask

  task automatic check_log(input int n, input string tag);
    check({tag, "_count"}, 32'(oam_log.size()), 32'(n));
    for (int i = 0; i < n && i < oam_log.size(); i++)
      check({tag, "_byte"}, 32'(oam_log[i]), 32'(8'(i) ^ 8'h5A));
  endtask

  initial begin
    bit ab;
    reset_i = 1'b0;
    bus_tick_i = 1'b0;
    mem_model_en = 1'b0;
    tb_mem_data = 8'h00;
    bus.mem_data_valid_i = 1'b0;
    idle_traffic(1'b1);
    #1;
    check("reset_dma_active", 32'(dma_active_o), 32'd0);
    step();
    step();
    reset_i = 1'b1;
    step();

    // Passthrough read of the reset vector
    bus_tick_i = 1'b1;
    bus.cpu_address_valid_i = 1'b1;
    bus.cpu_data_write_i = 1'b0;
    bus.cpu_address_i = 16'hFFFC;
    tb_mem_data = 8'h34;
    bus.mem_data_valid_i = 1'b1;
    #1;
    check("pt_addr", 32'(bus.mem_address_o), 32'h0000FFFC);
    check("pt_read", 32'(bus.mem_read_o), 32'd1);
    check("pt_cpu_data", 32'(bus.cpu_data_o), 32'h34);
    check("pt_cpu_valid", 32'(bus.cpu_data_valid_o), 32'd1);
    check("pt_dma_active", 32'(dma_active_o), 32'd0);
    step();

    for (int c = 0; c < 200; c++) begin
      bus_tick_i = ($urandom_range(0, 3) != 0);
      idle_traffic(1'b0);
      tb_mem_data = 8'($urandom);
      bus.mem_data_valid_i = 1'($urandom_range(0, 1));
      step();
    end
    mem_model_en = 1'b1;
    bus.mem_data_valid_i = 1'b1;

    do_trigger(1'b1, 8'h02);
    run_dma(1'b0, 0, 0, ab);
    check("latency_odd", 32'(act_ticks), 32'd513);
    check_log(256, "odd");
    if (oam_log.size() == 256) begin
      check("first_byte", 32'(oam_log[0]), 32'h5A);
      check("last_byte", 32'(oam_log[255]), 32'hA5);
    end

    do_trigger(1'b0, 8'h02);
    run_dma(1'b0, 0, 0, ab);
    check("latency_even", 32'(act_ticks), 32'd514);
    check_log(256, "even");

    do_trigger(1'b1, 8'h02);
    run_dma(1'b0, 1, 0, ab);
    check("latency_wait", 32'(act_ticks), 32'd516);
    check_log(256, "wait");

    do_trigger(1'b1, 8'h02);
    run_dma(1'b1, 0, 0, ab);
    check("latency_noise", 32'(act_ticks), 32'd513);
    for (int c = 0; c < 50; c++) begin
      bus_tick_i = 1'b1;
      step();
    end
    check_log(256, "noise");

    do_trigger(1'b0, 8'h02);
    run_dma(1'b0, 0, 40, ab);
    check("aborted_at_40", 32'(ab), 32'd1);
    reset_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    for (int c = 0; c < 600; c++) begin
      bus_tick_i = ($urandom_range(0, 3) != 0);
      idle_traffic(1'b0);
      step();
    end
    check("no_write_after_abort", 32'(oam_log.size()), 32'd40);

    do_trigger(1'b0, 8'h03);
    run_dma(1'b0, 2, 0, ab);
    check_log(256, "restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
